rangefinder_spi_sequencer: RTL and testbench

Sequences multi-byte SPI transactions on the rangefinder's SPI master core by driving its Avalon-style register port, the same way a CPU would. It takes a command (slave index, byte count) plus a 16-byte TX buffer. It then selects the slave, holds SS_n asserted for the whole burst, moves each byte through the core, collects the received bytes into an RX buffer, and reports done or error. It sits between the measurement FSM and the SPI core, so laser/ADC readout needs no CPU involvement.

---
 rtl/rangefinder_spi_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_rangefinder_spi_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rangefinder_spi_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rangefinder_spi_sequencer
// Brief    : Drives the SPI master core register port to run multi-byte
//            bursts from a 16-byte TX buffer into a 16-byte RX buffer.
// Revision : 1.0 - initial release
// ============================================================================
module rangefinder_spi_sequencer #(
    parameter int POLL_LIMIT = 1023,
    parameter int MAX_LEN    = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_slave,
    input  logic [4:0]  cmd_len,
    input  logic        tx_wr_en,
    input  logic [3:0]  tx_wr_addr,
    input  logic [7:0]  tx_wr_data,
    input  logic [3:0]  rx_rd_addr,
    output logic [7:0]  rx_rd_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        spi_select,
    output logic        spi_read_n,
    output logic        spi_write_n,
    output logic [2:0]  spi_addr,
    output logic [15:0] spi_wdata,
    input  logic [15:0] spi_rdata
);

    localparam int       c_POLL_W      = $clog2(POLL_LIMIT + 1);
    localparam logic [1:0] c_ERR_NONE    = 2'd0;
    localparam logic [1:0] c_ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] c_ERR_LEN     = 2'd2;
    localparam logic [1:0] c_ERR_OVR     = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_CHK    = 4'd1,
        S_CLR    = 4'd2,
        S_SEL    = 4'd3,
        S_SSO    = 4'd4,
        S_P_TRDY = 4'd5,
        S_WR     = 4'd6,
        S_P_RRDY = 4'd7,
        S_RD     = 4'd8,
        S_P_TMT  = 4'd9,
        S_DESEL  = 4'd10,
        S_FIN    = 4'd11
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [1:0]            r_phase;
    logic [1:0]            w_phase_next;
    logic [c_POLL_W-1:0]   r_poll_cnt;
    logic [3:0]            r_idx;
    logic [4:0]            r_len;
    logic [2:0]            r_slave;
    logic                  r_err;
    logic [1:0]            r_err_code;
    logic [7:0]            r_rx_rd_data;
    logic [7:0]            r_tx_buf [MAX_LEN];
    logic [7:0]            r_rx_buf [MAX_LEN];

    logic                  w_access;
    logic                  w_is_read;
    logic                  w_strobe;
    logic                  w_prim_end;
    logic                  w_poll_bit;
    logic                  w_status_bad;
    logic                  w_poll_exhausted;
    logic [2:0]            w_addr;
    logic [15:0]           w_wdata;
    logic                  w_accept;
    logic                  w_set_err;
    logic [1:0]            w_err_val;
    logic                  w_rx_we;
    logic                  w_poll_inc;
    logic                  w_unused;

    // Which register each access state touches, and the status bit it waits on.
    always_comb begin
        w_access   = 1'b0;
        w_is_read  = 1'b0;
        w_poll_bit = 1'b0;
        w_addr     = 3'd0;
        w_wdata    = 16'd0;
        case (r_state)
            S_CLR:    begin w_access = 1'b1; w_addr = 3'd2; end
            S_SEL:    begin w_access = 1'b1; w_addr = 3'd5; w_wdata = {8'h00, 8'b1 << r_slave}; end
            S_SSO:    begin w_access = 1'b1; w_addr = 3'd3; w_wdata = 16'h0400; end
            S_P_TRDY: begin w_access = 1'b1; w_is_read = 1'b1; w_addr = 3'd2; w_poll_bit = spi_rdata[6]; end
            S_WR:     begin w_access = 1'b1; w_addr = 3'd1; w_wdata = {8'h00, r_tx_buf[r_idx]}; end
            S_P_RRDY: begin w_access = 1'b1; w_is_read = 1'b1; w_addr = 3'd2; w_poll_bit = spi_rdata[7]; end
            S_RD:     begin w_access = 1'b1; w_is_read = 1'b1; w_addr = 3'd0; end
            S_P_TMT:  begin w_access = 1'b1; w_is_read = 1'b1; w_addr = 3'd2; w_poll_bit = spi_rdata[5]; end
            S_DESEL:  begin w_access = 1'b1; w_addr = 3'd3; end
            default:  begin w_access = 1'b0; end
        endcase
    end

    // Phases 0 and 1 strobe the core; phase 2 is the idle cycle where read data lands.
    assign w_strobe         = w_access && (r_phase != 2'd2);
    assign w_prim_end       = w_access && (r_phase == 2'd2);
    assign w_status_bad     = spi_rdata[4] | spi_rdata[3];
    assign w_poll_exhausted = ({{(32-c_POLL_W){1'b0}}, r_poll_cnt} + 32'd1) >= 32'(POLL_LIMIT);
    assign w_unused         = ^{spi_rdata[15:8]};

    assign spi_select  = w_strobe;
    assign spi_read_n  = !(w_strobe && w_is_read);
    assign spi_write_n = !(w_strobe && !w_is_read);
    assign spi_addr    = w_strobe ? w_addr : 3'd0;
    assign spi_wdata   = w_strobe ? w_wdata : 16'd0;

    assign cmd_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_FIN);
    assign err        = r_err;
    assign err_code   = r_err_code;
    assign rx_rd_data = r_rx_rd_data;

    always_comb begin
        w_state_next = r_state;
        w_phase_next = w_access ? ((r_phase == 2'd2) ? 2'd0 : r_phase + 2'd1) : 2'd0;
        w_accept     = 1'b0;
        w_set_err    = 1'b0;
        w_err_val    = c_ERR_NONE;
        w_rx_we      = 1'b0;
        w_poll_inc   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_CHK;
                end
            end
            S_CHK: begin
                if (r_len == 5'd0 || r_len > 5'(MAX_LEN)) begin
                    w_set_err    = 1'b1;
                    w_err_val    = c_ERR_LEN;
                    w_state_next = S_FIN;
                end else begin
                    w_state_next = S_CLR;
                end
            end
            S_CLR:   if (w_prim_end) w_state_next = S_SEL;
            S_SEL:   if (w_prim_end) w_state_next = S_SSO;
            S_SSO:   if (w_prim_end) w_state_next = S_P_TRDY;
            S_WR:    if (w_prim_end) w_state_next = S_P_RRDY;
            S_DESEL: if (w_prim_end) w_state_next = S_FIN;
            S_RD: begin
                if (w_prim_end) begin
                    w_rx_we      = 1'b1;
                    w_state_next = (({1'b0, r_idx} + 5'd1) == r_len) ? S_P_TMT : S_P_TRDY;
                end
            end
            S_P_TRDY, S_P_RRDY, S_P_TMT: begin
                if (w_prim_end) begin
                    if (w_status_bad) begin
                        w_set_err    = 1'b1;
                        w_err_val    = c_ERR_OVR;
                        w_state_next = S_DESEL;
                    end else if (w_poll_bit) begin
                        w_state_next = (r_state == S_P_TRDY) ? S_WR :
                                       (r_state == S_P_RRDY) ? S_RD : S_DESEL;
                    end else if (w_poll_exhausted) begin
                        w_set_err    = 1'b1;
                        w_err_val    = c_ERR_TIMEOUT;
                        w_state_next = S_DESEL;
                    end else begin
                        w_poll_inc   = 1'b1;
                    end
                end
            end
            S_FIN:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_phase      <= 2'd0;
            r_poll_cnt   <= '0;
            r_idx        <= 4'd0;
            r_len        <= 5'd0;
            r_slave      <= 3'd0;
            r_err        <= 1'b0;
            r_err_code   <= c_ERR_NONE;
            r_rx_rd_data <= 8'd0;
        end else begin
            r_state      <= w_state_next;
            r_phase      <= w_phase_next;
            r_rx_rd_data <= r_rx_buf[rx_rd_addr];
            if (w_state_next != r_state) begin
                r_poll_cnt <= '0;
            end else if (w_poll_inc) begin
                r_poll_cnt <= r_poll_cnt + 1'b1;
            end
            if (w_accept) begin
                r_len      <= cmd_len;
                r_slave    <= cmd_slave;
                r_idx      <= 4'd0;
                r_err      <= 1'b0;
                r_err_code <= c_ERR_NONE;
            end
            if (w_set_err) begin
                r_err      <= 1'b1;
                r_err_code <= w_err_val;
            end
            // Wraps 15->0 on the 16th byte; the 5-bit length compare ends the burst.
            if (w_rx_we) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (tx_wr_en) begin
            r_tx_buf[tx_wr_addr] <= tx_wr_data;
        end
        if (w_rx_we && reset_n) begin
            r_rx_buf[r_idx] <= spi_rdata[7:0];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rangefinder_spi_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rangefinder_spi_sequencer
// Brief    : Bench for the SPI sequencer with a loopback SPI core model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rangefinder_spi_sequencer;

    localparam int c_POLL_LIMIT    = 7;
    localparam int c_MODE_NORMAL   = 0;
    localparam int c_MODE_NO_TRDY  = 1;
    localparam int c_MODE_TOE      = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_slave = 3'd0;
    logic [4:0]  cmd_len = 5'd0;
    logic        tx_wr_en = 1'b0;
    logic [3:0]  tx_wr_addr = 4'd0;
    logic [7:0]  tx_wr_data = 8'd0;
    logic [3:0]  rx_rd_addr = 4'd0;
    logic [7:0]  rx_rd_data;
    logic        busy, done, err;
    logic [1:0]  err_code;
    logic        spi_select, spi_read_n, spi_write_n;
    logic [2:0]  spi_addr;
    logic [15:0] spi_wdata;
    logic [15:0] spi_rdata;

    always #5 clk = ~clk;

    rangefinder_spi_sequencer #(.POLL_LIMIT(c_POLL_LIMIT), .MAX_LEN(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_slave(cmd_slave), .cmd_len(cmd_len),
        .tx_wr_en(tx_wr_en), .tx_wr_addr(tx_wr_addr), .tx_wr_data(tx_wr_data),
        .rx_rd_addr(rx_rd_addr), .rx_rd_data(rx_rd_data),
        .busy(busy), .done(done), .err(err), .err_code(err_code),
        .spi_select(spi_select), .spi_read_n(spi_read_n), .spi_write_n(spi_write_n),
        .spi_addr(spi_addr), .spi_wdata(spi_wdata), .spi_rdata(spi_rdata)
    );

    // ---------------- SPI core model (loopback) ----------------
    int          core_mode = 0;
    int          cur_slave = 0;
    int          toe_arm = 0;
    int          toe_seen = 0;
    logic        trdy, rrdy, tmt, toe, roe, sso, shifting, in_burst;
    logic [7:0]  ssreg, txd, rxd;
    logic [7:0]  ss_n;
    int          shift_cnt;
    logic [15:0] rdata_q;
    int          run = 0;
    logic [2:0]  p_addr;
    logic [15:0] p_wdata;
    logic        p_rn;
    logic        proto_bad;
    int          proto_err = 0;
    int          wr_n = 0;
    int          stat_reads = 0;
    int          sel_cycles = 0;
    int          ss_high = 0;
    int          wr_a [1024];
    int          wr_d [1024];

    assign spi_rdata = rdata_q;
    assign ss_n      = ~(ssreg & {8{sso | shifting}});
    assign proto_bad = spi_select ?
        (run >= 2 || spi_read_n == spi_write_n ||
         (run == 1 && (spi_addr != p_addr || spi_wdata != p_wdata || spi_read_n != p_rn))) :
        (run == 1 || !spi_read_n || !spi_write_n);

    always @(posedge clk) begin
        p_addr  <= spi_addr;
        p_wdata <= spi_wdata;
        p_rn    <= spi_read_n;
        if (!reset_n) begin
            trdy <= 1'b1; rrdy <= 1'b0; tmt <= 1'b1; toe <= 1'b0; roe <= 1'b0;
            sso <= 1'b0; shifting <= 1'b0; in_burst <= 1'b0; ssreg <= 8'd0;
            txd <= 8'd0; rxd <= 8'd0; shift_cnt <= 0; rdata_q <= 16'd0; run <= 0;
        end else begin
            if (proto_bad) proto_err <= proto_err + 1;
            run <= spi_select ? run + 1 : 0;
            if (spi_select) sel_cycles <= sel_cycles + 1;
            if (in_burst && ss_n[cur_slave[2:0]]) ss_high <= ss_high + 1;
            if (shifting) begin
                if (shift_cnt <= 1) begin
                    shifting <= 1'b0; rxd <= txd; rrdy <= 1'b1; trdy <= 1'b1; tmt <= 1'b1;
                end else begin
                    shift_cnt <= shift_cnt - 1;
                end
            end
            if (spi_select && run == 1) begin
                if (!spi_write_n) begin
                    wr_a[wr_n % 1024] <= int'(spi_addr);
                    wr_d[wr_n % 1024] <= int'(spi_wdata);
                    wr_n <= wr_n + 1;
                    case (spi_addr)
                        3'd1: begin
                            txd <= spi_wdata[7:0]; trdy <= 1'b0; tmt <= 1'b0;
                            shifting <= 1'b1; shift_cnt <= $urandom_range(12, 2); in_burst <= 1'b1;
                        end
                        3'd2: begin toe <= 1'b0; roe <= 1'b0; end
                        3'd3: begin sso <= spi_wdata[10]; if (!spi_wdata[10]) in_burst <= 1'b0; end
                        3'd5: ssreg <= spi_wdata[7:0];
                        default: ;
                    endcase
                end else begin
                    case (spi_addr)
                        3'd0: begin rdata_q <= {8'h00, rxd}; rrdy <= 1'b0; end
                        3'd2: begin
                            stat_reads <= stat_reads + 1;
                            if (core_mode == c_MODE_TOE && toe_seen != toe_arm) begin
                                rdata_q  <= 16'h0010;
                                toe_seen <= toe_arm;
                            end else begin
                                rdata_q <= {8'h00, rrdy, trdy && (core_mode != c_MODE_NO_TRDY),
                                            tmt, toe, roe, 3'd0};
                            end
                        end
                        default: rdata_q <= 16'd0;
                    endcase
                end
            end
        end
    end

    // ---------------- checking ----------------
    int         tests_run = 0;
    int         tests_failed = 0;
    logic [7:0] tx_model [16];
    logic [7:0] exp_rx [16];
    bit         rx_known [16];

    typedef struct {
        int mode;
        int slave;
        int len;
        int tx_base;
        int exp_code;
    } vec_t;
    vec_t vecs [7];

    task automatic check(input string name, input int actual, input int expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic write_tx(input int a, input int d);
        tx_wr_en   = 1'b1;
        tx_wr_addr = a[3:0];
        tx_wr_data = d[7:0];
        tx_model[a[3:0]] = d[7:0];
        @(negedge clk);
        tx_wr_en = 1'b0;
    endtask

    task automatic start_cmd(input int mode, input int slave, input int len);
        core_mode = mode;
        cur_slave = slave;
        if (mode == c_MODE_TOE) toe_arm++;
        cmd_valid = 1'b1;
        cmd_slave = slave[2:0];
        cmd_len   = len[4:0];
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Runs one command and checks it against what the command should produce.
    task automatic run_txn(input string tag, input int mode, input int slave, input int len,
                           input int exp_code);
        int wr0, sr0, sc0, ss0, cyc, n;
        bit seen, legal;
        int ea[$];
        int ed[$];
        legal = (len >= 1 && len <= 16);
        wr0 = wr_n; sr0 = stat_reads; sc0 = sel_cycles; ss0 = ss_high;
        check({tag, " ready"}, int'(cmd_ready), 1);
        start_cmd(mode, slave, len);
        check({tag, " busy"}, int'(busy), 1);
        cyc = 0; seen = 0;
        while (!seen && cyc < 4000) begin
            if (done) seen = 1;
            else begin @(negedge clk); cyc++; end
        end
        check({tag, " done seen"}, int'(seen), 1);
        if (!seen) return;
        check({tag, " err"}, int'(err), (exp_code != 0) ? 1 : 0);
        check({tag, " err_code"}, int'(err_code), exp_code);
        check({tag, " ready at done"}, int'(cmd_ready), 0);
        if (legal) begin
            ea.push_back(2); ed.push_back(0);
            ea.push_back(5); ed.push_back(1 << slave);
            ea.push_back(3); ed.push_back('h400);
            if (mode == c_MODE_NORMAL)
                for (int i = 0; i < len; i++) begin ea.push_back(1); ed.push_back(int'(tx_model[i])); end
            ea.push_back(3); ed.push_back(0);
        end else begin
            check({tag, " done latency"}, int'(cyc + 1 <= 4), 1);
            check({tag, " select cycles"}, sel_cycles - sc0, 0);
        end
        n = wr_n - wr0;
        check({tag, " write count"}, n, ea.size());
        for (int i = 0; i < n && i < ea.size(); i++)
            check($sformatf("%s write %0d", tag, i), (wr_a[(wr0 + i) % 1024] << 16) | wr_d[(wr0 + i) % 1024],
                  (ea[i] << 16) | ed[i]);
        if (mode == c_MODE_NO_TRDY) check({tag, " status reads"}, stat_reads - sr0, c_POLL_LIMIT);
        if (mode == c_MODE_TOE)     check({tag, " status reads"}, stat_reads - sr0, 1);
        if (mode == c_MODE_NORMAL && legal) check({tag, " ss held"}, ss_high - ss0, 0);
        @(negedge clk);
        check({tag, " done pulse"}, int'(done), 0);
        check({tag, " ready after"}, int'(cmd_ready), 1);
        check({tag, " err sticky"}, int'(err), (exp_code != 0) ? 1 : 0);
        if (mode == c_MODE_NORMAL && legal)
            for (int i = 0; i < len; i++) begin exp_rx[i] = tx_model[i]; rx_known[i] = 1; end
        for (int i = 0; i < 16; i++) begin
            if (rx_known[i]) begin
                rx_rd_addr = i[3:0];
                @(negedge clk);
                check($sformatf("%s rx[%0d]", tag, i), int'(rx_rd_data), int'(exp_rx[i]));
            end
        end
    endtask

    initial begin
        int guard, wr0, slave, len, code;
        for (int i = 0; i < 16; i++) begin rx_known[i] = 0; exp_rx[i] = 8'd0; tx_model[i] = 8'd0; end
        vecs[0] = '{c_MODE_NORMAL,  2, 1,  'hA5, 0};
        vecs[1] = '{c_MODE_NORMAL,  5, 16, 'h00, 0};
        vecs[2] = '{c_MODE_NORMAL,  1, 0,  'h00, 2};
        vecs[3] = '{c_MODE_NORMAL,  4, 17, 'h00, 2};
        vecs[4] = '{c_MODE_NO_TRDY, 1, 4,  'h30, 1};
        vecs[5] = '{c_MODE_TOE,     7, 3,  'h50, 3};
        vecs[6] = '{c_MODE_NORMAL,  0, 2,  'hC0, 0};

        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst cmd_ready", int'(cmd_ready), 1);
        check("rst busy", int'(busy), 0);
        check("rst done", int'(done), 0);
        check("rst err", int'({err, err_code}), 0);
        check("rst strobes", int'({spi_select, spi_read_n, spi_write_n}), 3);
        check("rst addr/wdata", int'({spi_addr, spi_wdata}), 0);
        check("rst rx_rd_data", int'(rx_rd_data), 0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < vecs[v].len && i < 16; i++) write_tx(i, (vecs[v].tx_base + i) & 'hFF);
            run_txn($sformatf("vec%0d", v), vecs[v].mode, vecs[v].slave, vecs[v].len, vecs[v].exp_code);
        end

        // Reset pulse in the middle of byte 3 of an 8-byte burst.
        for (int i = 0; i < 8; i++) write_tx(i, $urandom_range(255, 0));
        wr0 = wr_n;
        start_cmd(c_MODE_NORMAL, 3, 8);
        guard = 0;
        while ((wr_n - wr0) < 6 && guard < 3000) begin @(negedge clk); guard++; end
        check("midrst reached byte3", int'((wr_n - wr0) >= 6), 1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("midrst strobes", int'({spi_select, spi_read_n, spi_write_n}), 3);
        check("midrst busy/done", int'({busy, done}), 0);
        check("midrst err", int'({err, err_code}), 0);
        for (int i = 0; i < 16; i++) rx_known[i] = 0;
        write_tx(0, 'h3C);
        write_tx(1, 'hC3);
        run_txn("after rst", c_MODE_NORMAL, 6, 2, 0);

        for (int r = 0; r < 12; r++) begin
            slave = $urandom_range(7, 0);
            if ($urandom_range(5, 0) == 0) len = ($urandom_range(1, 0) == 0) ? 0 : $urandom_range(31, 17);
            else len = $urandom_range(16, 1);
            code = (len >= 1 && len <= 16) ? 0 : 2;
            for (int i = 0; i < 16; i++)
                if ($urandom_range(1, 0) == 1) write_tx(i, $urandom_range(255, 0));
            run_txn($sformatf("rand%0d", r), c_MODE_NORMAL, slave, len, code);
        end

        check("strobe protocol errors", proto_err, 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
